// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer_if
//  Description : Handshake and serial-output bundle for bit_serializer.
//                master : word source / serial consumer (drives din, din_valid)
//                slave  : the serializer (drives din_ready, x, x_valid, status)
//  Signals     : din[WIDTH-1:0], din_valid, din_ready, x, x_valid, status[1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic [1:0]       status;

   modport master (
      output din, din_valid,
      input  din_ready, x, x_valid, status
   );

   modport slave (
      input  din, din_valid,
      output din_ready, x, x_valid, status
   );
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial front end. Takes WIDTH-bit words on a
//                valid/ready handshake and emits them one bit per clock on x.
//                x idles at 0 between words.
//  Ports       : clk          rising-edge clock
//                rst          asynchronous active-low reset
//                bus (slave)  din, din_valid -> ; din_ready, x, x_valid,
//                             status (0 IDLE, 1 SHIFT, 2 PARITY) <-
//  Parameters  : WIDTH (2..32), MSB_FIRST (1 = din[WIDTH-1] first)
//  Options     : `define SER_PARITY_EN appends one even-parity bit per word
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   bit_serializer_if.slave bus
);

   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               x_q,     x_d;
   logic               xv_q,    xv_d;
`ifdef SER_PARITY_EN
   logic               par_q,   par_d;
`endif

   logic               ready_w;
   logic               accept_w;
   logic               load_first_w;
   logic [WIDTH-1:0]   load_rest_w;
   logic               shift_next_w;
   logic [WIDTH-1:0]   shift_rest_w;

   // The shift register holds only the bits not yet presented; the bit going
   // out next always sits at the "first" end for the selected order.
   assign load_first_w = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
   assign load_rest_w  = MSB_FIRST ? (bus.din << 1)   : (bus.din >> 1);
   assign shift_next_w = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign shift_rest_w = MSB_FIRST ? (shreg_q << 1)   : (shreg_q >> 1);

   // Ready opens on the final output cycle of a word so the next word can
   // follow with no idle gap.
   always_comb begin
      ready_w = 1'b0;
      case (state_q)
         ST_IDLE:   ready_w = 1'b1;
`ifdef SER_PARITY_EN
         ST_PARITY: ready_w = 1'b1;
`else
         ST_SHIFT:  ready_w = (cnt_q == LAST_CNT);
`endif
         default:   ready_w = 1'b0;
      endcase
   end

   assign accept_w      = bus.din_valid & ready_w;
   assign bus.din_ready = rst & ready_w;
   assign bus.x         = x_q;
   assign bus.x_valid   = xv_q;
   assign bus.status    = state_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      x_d     = 1'b0;
      xv_d    = 1'b0;
`ifdef SER_PARITY_EN
      par_d   = par_q;
`endif
      if (accept_w) begin
         // A load wins over any shift; the old word's last bit has already
         // been on x for this whole cycle.
         state_d = ST_SHIFT;
         shreg_d = load_rest_w;
         cnt_d   = '0;
         x_d     = load_first_w;
         xv_d    = 1'b1;
`ifdef SER_PARITY_EN
         par_d   = ^bus.din;
`endif
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (cnt_q == LAST_CNT) begin
`ifdef SER_PARITY_EN
                  state_d = ST_PARITY;
                  x_d     = par_q;
                  xv_d    = 1'b1;
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  shreg_d = shift_rest_w;
                  cnt_d   = cnt_q + CNT_W'(1);
                  x_d     = shift_next_w;
                  xv_d    = 1'b1;
               end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: state_d = ST_IDLE;
`endif
            ST_IDLE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         x_q     <= 1'b0;
         xv_q    <= 1'b0;
`ifdef SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
`ifdef SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer. One MSB-first and one
//                LSB-first instance (WIDTH=8); expected serial bits are queued
//                when a word is offered and popped as x_valid bits appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int NB  = 9;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = 8;
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   q_m[$];
   bit   q_l[$];
   bit   exp_m, exp_l;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) bm ();
   bit_serializer_if #(.WIDTH(8)) bl ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

   // Scoreboard consumers: every data/parity bit must match the queue head.
   always @(negedge clk) begin
      if (bm.x_valid === 1'b1) begin
         checks++;
         if (q_m.size() == 0) begin
            errors++;
            $display("FAIL msb_bit: unexpected bit x=%b, required no bit", bm.x);
         end else begin
            exp_m = q_m.pop_front();
            if (bm.x !== exp_m) begin
               errors++;
               $display("FAIL msb_bit: got %b required %b at %0t", bm.x, exp_m, $time);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bl.x_valid === 1'b1) begin
         checks++;
         if (q_l.size() == 0) begin
            errors++;
            $display("FAIL lsb_bit: unexpected bit x=%b, required no bit", bl.x);
         end else begin
            exp_l = q_l.pop_front();
            if (bl.x !== exp_l) begin
               errors++;
               $display("FAIL lsb_bit: got %b required %b at %0t", bl.x, exp_l, $time);
            end
         end
      end
   end

   task automatic push_word(input logic [7:0] d, input bit msb);
      if (msb) begin
         for (int i = 7; i >= 0; i--) q_m.push_back(d[i]);
         if (PAR) q_m.push_back(^d);
      end else begin
         for (int i = 0; i < 8; i++) q_l.push_back(d[i]);
         if (PAR) q_l.push_back(^d);
      end
   endtask

   task automatic test_reset();
      logic [4:0] got;
      bm.din = '0; bm.din_valid = 1'b0;
      bl.din = '0; bl.din_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      got = {bm.x, bm.x_valid, bm.status, bm.din_ready};
      checks++;
      if (got !== 5'b0) begin
         errors++;
         $display("FAIL reset_msb: {x,xv,status,ready} got %b required 00000", got);
      end
      got = {bl.x, bl.x_valid, bl.status, bl.din_ready};
      checks++;
      if (got !== 5'b0) begin
         errors++;
         $display("FAIL reset_lsb: {x,xv,status,ready} got %b required 00000", got);
      end
      #2 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bm.din_ready, bm.status} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release: {ready,status} got %b required 100", {bm.din_ready, bm.status});
      end
   endtask

   task automatic test_single(input logic [7:0] d);
      logic [3:0] got, exp;
      @(negedge clk);
      bm.din = d; bm.din_valid = 1'b1;
      checks++;
      if (bm.din_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready_idle: got %b required 1", bm.din_ready);
      end
      push_word(d, 1'b1);
      for (int k = 1; k <= NB + 1; k++) begin
         @(negedge clk);
         got = {bm.x_valid, bm.status, bm.din_ready};
         exp[3]   = (k <= NB);
         exp[2:1] = (k > NB) ? 2'd0 : ((k == 9) ? 2'd2 : 2'd1);
         exp[0]   = (k >= NB);
         checks++;
         if (got !== exp || (!exp[3] && bm.x !== 1'b0)) begin
            errors++;
            $display("FAIL single_%h cycle %0d: {xv,status,ready} got %b required %b, x=%b",
                     d, k, got, exp, bm.x);
         end
         if (k == 1) begin
            bm.din_valid = 1'b0;
            bm.din = ~d;
         end
      end
      checks++;
      if (q_m.size() != 0) begin
         errors++;
         $display("FAIL single_%h_drain: %0d bits left, required 0", d, q_m.size());
      end
   endtask

   // First word, then the second held valid from cycle 1 until it is taken.
   task automatic test_back_to_back(input logic [7:0] d1, input logic [7:0] d2,
                                    input int exp_run);
      int acc = 0, nvalid = 0, run = 0, maxrun = 0;
      @(negedge clk);
      bm.din = d1; bm.din_valid = 1'b1;
      push_word(d1, 1'b1);
      for (int k = 1; k <= 2 * NB + 3; k++) begin
         @(negedge clk);
         if (bm.x_valid === 1'b1) nvalid++;
         run = (bm.x_valid === 1'b1 && bm.x === 1'b1) ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         if (k == 1) bm.din = d2;
         if (acc == 0 && k > 1 && bm.din_ready === 1'b1) begin
            acc = k;
            push_word(d2, 1'b1);
         end else if (acc != 0 && bm.din_valid) begin
            bm.din_valid = 1'b0;
         end
      end
      bm.din_valid = 1'b0;
      checks++;
      if (acc != NB) begin
         errors++;
         $display("FAIL b2b_%h_%h accept_cycle: got %0d required %0d", d1, d2, acc, NB);
      end
      checks++;
      if (nvalid != 2 * NB) begin
         errors++;
         $display("FAIL b2b_%h_%h valid_cycles: got %0d required %0d", d1, d2, nvalid, 2 * NB);
      end
      checks++;
      if (maxrun != exp_run) begin
         errors++;
         $display("FAIL b2b_%h_%h ones_run: got %0d required %0d", d1, d2, maxrun, exp_run);
      end
      checks++;
      if (q_m.size() != 0) begin
         errors++;
         $display("FAIL b2b_%h_%h drain: %0d bits left, required 0", d1, d2, q_m.size());
      end
   endtask

   task automatic test_lsb_first(input logic [7:0] d);
      @(negedge clk);
      bl.din = d; bl.din_valid = 1'b1;
      push_word(d, 1'b0);
      for (int k = 1; k <= NB + 1; k++) begin
         @(negedge clk);
         if (k == 1) bl.din_valid = 1'b0;
         checks++;
         if (bl.x_valid !== (k <= NB)) begin
            errors++;
            $display("FAIL lsb_%h xv cycle %0d: got %b required %b", d, k, bl.x_valid, (k <= NB));
         end
      end
      checks++;
      if (q_l.size() != 0) begin
         errors++;
         $display("FAIL lsb_%h drain: %0d bits left, required 0", d, q_l.size());
      end
   endtask

   task automatic test_reset_mid_word();
      logic [4:0] got;
      @(negedge clk);
      bm.din = 8'hFF; bm.din_valid = 1'b1;
      push_word(8'hFF, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         bm.din_valid = 1'b0;
      end
      #2;
      q_m.delete();
      rst = 1'b0;
      #1;
      got = {bm.x, bm.x_valid, bm.status, bm.din_ready};
      checks++;
      if (got !== 5'b0) begin
         errors++;
         $display("FAIL reset_async: {x,xv,status,ready} got %b required 00000", got);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         got = {bm.x, bm.x_valid, bm.status, 1'b0};
         checks++;
         if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_after cycle %0d: {x,xv,status} got %b required 0000", k, got[4:1]);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single(8'hF0);
      test_single(8'h07);
      test_single(8'h03);
      test_back_to_back(8'hFF, 8'hFF, PAR ? 8 : 16);
      test_back_to_back(8'hFF, 8'hAA, PAR ? 8 : 9);
      test_lsb_first(8'h01);
      test_lsb_first(8'h80);
      test_reset_mid_word();
      test_single(8'h5A);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
